// File: rtl/gba_line_cache_pkg.sv
// Shared definitions for the GBA line cache.
// Holds the line/frame geometry, the bank ring size, derived index widths
// and the 24-bit pixel type used on both sides of the cache.
package gba_line_cache_pkg;

  localparam int LINE_PIXELS = 240;
  localparam int FRAME_LINES = 160;
  localparam int NUM_BANKS   = 4;

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int PXL_W  = 8;
  localparam int LINE_W = 8;

  localparam logic [PXL_W-1:0]  PXL_LAST  = PXL_W'(LINE_PIXELS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(FRAME_LINES);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Requests past the right edge read the last pixel of the line.
  function automatic logic [PXL_W-1:0] clamp_col(input logic [PXL_W-1:0] c);
    return (c > PXL_LAST) ? PXL_LAST : c;
  endfunction

endpackage

// File: rtl/gba_line_cache_if.sv
// Bus between the capture path / HDMI image generator and the line cache.
//   capture : pxlIn{Red,Green,Blue}, pxlInValid, lineStartIn, frameStartIn
//   request : nextLine, cacheUpdate, curPxl
//   window  : {prev,cur,next}Line{Prev,Cur,Next}Pxl{Red,Green,Blue}In
//   status  : sameLine, newFrame, overrunErr
// master = capture/generator side, slave = the cache.
interface gba_line_cache_if;

  logic [7:0] pxlInRed, pxlInGreen, pxlInBlue;
  logic       pxlInValid, lineStartIn, frameStartIn;
  logic       nextLine, cacheUpdate;
  logic [7:0] curPxl;

  logic [7:0] prevLinePrevPxlRedIn, prevLinePrevPxlGreenIn, prevLinePrevPxlBlueIn;
  logic [7:0] prevLineCurPxlRedIn,  prevLineCurPxlGreenIn,  prevLineCurPxlBlueIn;
  logic [7:0] prevLineNextPxlRedIn, prevLineNextPxlGreenIn, prevLineNextPxlBlueIn;
  logic [7:0] curLinePrevPxlRedIn,  curLinePrevPxlGreenIn,  curLinePrevPxlBlueIn;
  logic [7:0] curLineCurPxlRedIn,   curLineCurPxlGreenIn,   curLineCurPxlBlueIn;
  logic [7:0] curLineNextPxlRedIn,  curLineNextPxlGreenIn,  curLineNextPxlBlueIn;
  logic [7:0] nextLinePrevPxlRedIn, nextLinePrevPxlGreenIn, nextLinePrevPxlBlueIn;
  logic [7:0] nextLineCurPxlRedIn,  nextLineCurPxlGreenIn,  nextLineCurPxlBlueIn;
  logic [7:0] nextLineNextPxlRedIn, nextLineNextPxlGreenIn, nextLineNextPxlBlueIn;

  logic       sameLine, newFrame, overrunErr;

  modport master (
    output pxlInRed, pxlInGreen, pxlInBlue, pxlInValid, lineStartIn, frameStartIn,
    output nextLine, cacheUpdate, curPxl,
    input  prevLinePrevPxlRedIn, prevLinePrevPxlGreenIn, prevLinePrevPxlBlueIn,
    input  prevLineCurPxlRedIn,  prevLineCurPxlGreenIn,  prevLineCurPxlBlueIn,
    input  prevLineNextPxlRedIn, prevLineNextPxlGreenIn, prevLineNextPxlBlueIn,
    input  curLinePrevPxlRedIn,  curLinePrevPxlGreenIn,  curLinePrevPxlBlueIn,
    input  curLineCurPxlRedIn,   curLineCurPxlGreenIn,   curLineCurPxlBlueIn,
    input  curLineNextPxlRedIn,  curLineNextPxlGreenIn,  curLineNextPxlBlueIn,
    input  nextLinePrevPxlRedIn, nextLinePrevPxlGreenIn, nextLinePrevPxlBlueIn,
    input  nextLineCurPxlRedIn,  nextLineCurPxlGreenIn,  nextLineCurPxlBlueIn,
    input  nextLineNextPxlRedIn, nextLineNextPxlGreenIn, nextLineNextPxlBlueIn,
    input  sameLine, newFrame, overrunErr
  );

  modport slave (
    input  pxlInRed, pxlInGreen, pxlInBlue, pxlInValid, lineStartIn, frameStartIn,
    input  nextLine, cacheUpdate, curPxl,
    output prevLinePrevPxlRedIn, prevLinePrevPxlGreenIn, prevLinePrevPxlBlueIn,
    output prevLineCurPxlRedIn,  prevLineCurPxlGreenIn,  prevLineCurPxlBlueIn,
    output prevLineNextPxlRedIn, prevLineNextPxlGreenIn, prevLineNextPxlBlueIn,
    output curLinePrevPxlRedIn,  curLinePrevPxlGreenIn,  curLinePrevPxlBlueIn,
    output curLineCurPxlRedIn,   curLineCurPxlGreenIn,   curLineCurPxlBlueIn,
    output curLineNextPxlRedIn,  curLineNextPxlGreenIn,  curLineNextPxlBlueIn,
    output nextLinePrevPxlRedIn, nextLinePrevPxlGreenIn, nextLinePrevPxlBlueIn,
    output nextLineCurPxlRedIn,  nextLineCurPxlGreenIn,  nextLineCurPxlBlueIn,
    output nextLineNextPxlRedIn, nextLineNextPxlGreenIn, nextLineNextPxlBlueIn,
    output sameLine, newFrame, overrunErr
  );

endinterface

// File: rtl/gba_line_cache_line_bank_ram.sv
// Line-bank RAM: NUM_BANKS x LINE_PIXELS words of 24-bit RGB.
//   pxlClk          clock
//   we/wr_bank/wr_pxl/wr_data   single write port
//   rd_bank         bank (window row) served by this copy
//   rd_pxl[3]       column addresses (prev, cur, next), already clamped
//   rd_data[3]      registered read data, one cycle after address
// One copy exists per window row; all copies receive the same writes.
module gba_line_cache_line_bank_ram
  import gba_line_cache_pkg::*;
(
  input  logic              pxlClk,
  input  logic              we,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [PXL_W-1:0]  wr_pxl,
  input  rgb888_t           wr_data,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [PXL_W-1:0]  rd_pxl [3],
  output rgb888_t           rd_data [3]
);

  rgb888_t mem [NUM_BANKS][LINE_PIXELS];

  always_ff @(posedge pxlClk) begin
    if (we) mem[wr_bank][wr_pxl] <= wr_data;
    for (int i = 0; i < 3; i++) rd_data[i] <= mem[rd_bank][rd_pxl[i]];
  end

endmodule

// File: rtl/gba_line_cache.sv
// GBA line cache: captures the GBA pixel stream into a 4-line ring and
// serves a registered 3x3 RGB neighbourhood to the HDMI image generator.
//   pxlClk  clock (rising edge)
//   rstN    asynchronous active-low reset
//   bus     gba_line_cache_if.slave (capture, requests, window, status)
// Window latency: curPxl changing at edge N is visible after edge N+2
// (stage 1 RAM read, stage 2 row clamp + output register).
module gba_line_cache
  import gba_line_cache_pkg::*;
(
  input  logic            pxlClk,
  input  logic            rstN,
  gba_line_cache_if.slave bus
);

  logic [BANK_W-1:0] wr_bank, rd_bank, wr_bank_nxt, rd_bank_prev, rd_bank_next;
  logic [PXL_W-1:0]  wr_pxl;
  logic [LINE_W-1:0] wr_line, rd_line;
  logic              adv_pending, frame_pending;
  logic              pxl_wr, line_done;
  logic              same_line_q, new_frame_q, overrun_q;
  logic              clamp_prev_q, clamp_next_q;
  rgb888_t           pxl_in;
  logic [PXL_W-1:0]  col_c;
  logic [PXL_W-1:0]  rd_col [3];
  rgb888_t           prev_d [3];
  rgb888_t           cur_d [3];
  rgb888_t           next_d [3];
  rgb888_t           win_q [3][3];

  assign pxl_in       = '{r: bus.pxlInRed, g: bus.pxlInGreen, b: bus.pxlInBlue};
  // Line/frame starts take the cycle; pixels past the line end are dropped.
  assign pxl_wr       = bus.pxlInValid && !bus.lineStartIn && !bus.frameStartIn &&
                        (wr_pxl <= PXL_LAST);
  assign line_done    = pxl_wr && (wr_pxl == PXL_LAST);
  assign wr_bank_nxt  = wr_bank + 1'b1;
  assign rd_bank_prev = rd_bank - 1'b1;
  assign rd_bank_next = rd_bank + 1'b1;

  // Write side
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      wr_bank     <= '0;
      wr_pxl      <= '0;
      wr_line     <= '0;
      overrun_q   <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      new_frame_q <= 1'b0;
      if (bus.frameStartIn) begin
        wr_line   <= '0;
        wr_pxl    <= '0;
        overrun_q <= 1'b0;
      end else if (bus.lineStartIn) begin
        wr_pxl <= '0;
      end else if (pxl_wr) begin
        wr_pxl <= wr_pxl + 1'b1;
        if (line_done) begin
          wr_bank <= wr_bank_nxt;
          if (wr_line != LINE_END) wr_line <= wr_line + 1'b1;
          if (wr_line == LINE_W'(1)) new_frame_q <= 1'b1;
          if ((wr_bank_nxt == rd_bank_prev) && (rd_line != '0)) overrun_q <= 1'b1;
        end
      end
    end
  end

  // Read window position; only moves on cacheUpdate so a line never tears.
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      rd_bank       <= '0;
      rd_line       <= '0;
      adv_pending   <= 1'b0;
      frame_pending <= 1'b0;
    end else begin
      if (bus.cacheUpdate && frame_pending) begin
        rd_line       <= '0;
        rd_bank       <= wr_bank;
        adv_pending   <= 1'b0;
        frame_pending <= 1'b0;
      end else if (bus.cacheUpdate && (adv_pending || bus.nextLine)) begin
        rd_bank     <= rd_bank_next;
        if (rd_line != LINE_LAST) rd_line <= rd_line + 1'b1;
        adv_pending <= 1'b0;
      end else if (bus.nextLine) begin
        adv_pending <= 1'b1;
      end
      if (bus.frameStartIn) frame_pending <= 1'b1;
    end
  end

  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) same_line_q <= 1'b1;
    else       same_line_q <= ({1'b0, wr_line} <= ({1'b0, rd_line} + 9'd1)) &&
                              (wr_line < LINE_END);
  end

  // Stage 0: column addresses, clamped to the line edges.
  assign col_c     = clamp_col(bus.curPxl);
  assign rd_col[0] = (col_c == '0) ? '0 : col_c - 1'b1;
  assign rd_col[1] = col_c;
  assign rd_col[2] = (col_c == PXL_LAST) ? PXL_LAST : col_c + 1'b1;

  gba_line_cache_line_bank_ram u_ram_prev (
    .pxlClk(pxlClk), .we(pxl_wr), .wr_bank(wr_bank), .wr_pxl(wr_pxl), .wr_data(pxl_in),
    .rd_bank(rd_bank_prev), .rd_pxl(rd_col), .rd_data(prev_d)
  );
  gba_line_cache_line_bank_ram u_ram_cur (
    .pxlClk(pxlClk), .we(pxl_wr), .wr_bank(wr_bank), .wr_pxl(wr_pxl), .wr_data(pxl_in),
    .rd_bank(rd_bank), .rd_pxl(rd_col), .rd_data(cur_d)
  );
  gba_line_cache_line_bank_ram u_ram_next (
    .pxlClk(pxlClk), .we(pxl_wr), .wr_bank(wr_bank), .wr_pxl(wr_pxl), .wr_data(pxl_in),
    .rd_bank(rd_bank_next), .rd_pxl(rd_col), .rd_data(next_d)
  );

  // Stage 1: row clamp flags travel alongside the RAM read.
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      clamp_prev_q <= 1'b1;
      clamp_next_q <= 1'b0;
    end else begin
      clamp_prev_q <= (rd_line == '0);
      clamp_next_q <= (rd_line == LINE_LAST);
    end
  end

  // Stage 2: top/bottom frame rows reuse the current row.
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < 3; c++) begin
        win_q[0][c] <= '0;
        win_q[1][c] <= '0;
        win_q[2][c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        win_q[0][c] <= clamp_prev_q ? cur_d[c] : prev_d[c];
        win_q[1][c] <= cur_d[c];
        win_q[2][c] <= clamp_next_q ? cur_d[c] : next_d[c];
      end
    end
  end

  assign bus.sameLine   = same_line_q;
  assign bus.newFrame   = new_frame_q;
  assign bus.overrunErr = overrun_q;

  assign {bus.prevLinePrevPxlRedIn, bus.prevLinePrevPxlGreenIn, bus.prevLinePrevPxlBlueIn} = win_q[0][0];
  assign {bus.prevLineCurPxlRedIn,  bus.prevLineCurPxlGreenIn,  bus.prevLineCurPxlBlueIn}  = win_q[0][1];
  assign {bus.prevLineNextPxlRedIn, bus.prevLineNextPxlGreenIn, bus.prevLineNextPxlBlueIn} = win_q[0][2];
  assign {bus.curLinePrevPxlRedIn,  bus.curLinePrevPxlGreenIn,  bus.curLinePrevPxlBlueIn}  = win_q[1][0];
  assign {bus.curLineCurPxlRedIn,   bus.curLineCurPxlGreenIn,   bus.curLineCurPxlBlueIn}   = win_q[1][1];
  assign {bus.curLineNextPxlRedIn,  bus.curLineNextPxlGreenIn,  bus.curLineNextPxlBlueIn}  = win_q[1][2];
  assign {bus.nextLinePrevPxlRedIn, bus.nextLinePrevPxlGreenIn, bus.nextLinePrevPxlBlueIn} = win_q[2][0];
  assign {bus.nextLineCurPxlRedIn,  bus.nextLineCurPxlGreenIn,  bus.nextLineCurPxlBlueIn}  = win_q[2][1];
  assign {bus.nextLineNextPxlRedIn, bus.nextLineNextPxlGreenIn, bus.nextLineNextPxlBlueIn} = win_q[2][2];

endmodule

// File: tb/tb_gba_line_cache.sv
module tb_gba_line_cache;

  logic pxlClk;
  logic rstN;
  int   n_tests, n_fail, nf_count;

  // Reference image: every pixel written, indexed by frame line number.
  logic [23:0] ref_pix [160][240];

  gba_line_cache_if bus();

  gba_line_cache dut (.pxlClk(pxlClk), .rstN(rstN), .bus(bus));

  initial pxlClk = 1'b0;
  always #5 pxlClk = ~pxlClk;

  always @(negedge pxlClk) if (rstN && bus.newFrame) nf_count++;

  task automatic tick();
    @(posedge pxlClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] win(input int r, input int c);
    case (r * 3 + c)
      0: return {bus.prevLinePrevPxlRedIn, bus.prevLinePrevPxlGreenIn, bus.prevLinePrevPxlBlueIn};
      1: return {bus.prevLineCurPxlRedIn,  bus.prevLineCurPxlGreenIn,  bus.prevLineCurPxlBlueIn};
      2: return {bus.prevLineNextPxlRedIn, bus.prevLineNextPxlGreenIn, bus.prevLineNextPxlBlueIn};
      3: return {bus.curLinePrevPxlRedIn,  bus.curLinePrevPxlGreenIn,  bus.curLinePrevPxlBlueIn};
      4: return {bus.curLineCurPxlRedIn,   bus.curLineCurPxlGreenIn,   bus.curLineCurPxlBlueIn};
      5: return {bus.curLineNextPxlRedIn,  bus.curLineNextPxlGreenIn,  bus.curLineNextPxlBlueIn};
      6: return {bus.nextLinePrevPxlRedIn, bus.nextLinePrevPxlGreenIn, bus.nextLinePrevPxlBlueIn};
      7: return {bus.nextLineCurPxlRedIn,  bus.nextLineCurPxlGreenIn,  bus.nextLineCurPxlBlueIn};
      default: return {bus.nextLineNextPxlRedIn, bus.nextLineNextPxlGreenIn, bus.nextLineNextPxlBlueIn};
    endcase
  endfunction

  task automatic put_pxl(input logic [23:0] v);
    if ($urandom_range(0, 7) == 0) tick();
    {bus.pxlInRed, bus.pxlInGreen, bus.pxlInBlue} = v;
    bus.pxlInValid = 1'b1;
    tick();
    bus.pxlInValid = 1'b0;
  endtask

  // ln < 0: line content is not recorded (never read back).
  task automatic write_line(input int ln, input int extra, input bit use_5a, input bit mid_chk);
    logic [23:0] v;
    bus.lineStartIn = 1'b1;
    tick();
    bus.lineStartIn = 1'b0;
    for (int p = 0; p < 240; p++) begin
      v = {8'(ln), 8'(p), use_5a ? 8'h5A : 8'($urandom)};
      if (ln >= 0) ref_pix[ln][p] = v;
      put_pxl(v);
      if (mid_chk && p == 120) check("same_line_mid_line", 32'(bus.sameLine), 32'd1);
    end
    for (int e = 0; e < extra; e++) put_pxl(24'($urandom));
    tick();
  endtask

  task automatic pulse_next();
    bus.nextLine = 1'b1; tick(); bus.nextLine = 1'b0;
  endtask

  task automatic pulse_update();
    bus.cacheUpdate = 1'b1; tick(); bus.cacheUpdate = 1'b0;
  endtask

  task automatic pulse_both();
    bus.nextLine = 1'b1; bus.cacheUpdate = 1'b1; tick();
    bus.nextLine = 1'b0; bus.cacheUpdate = 1'b0;
  endtask

  // Expected window from frame-line numbers with edge clamping.
  task automatic chk_win(input int rl, input int px, input string tag);
    int cc, row, col;
    bus.curPxl = 8'(px);
    tick();
    tick();
    cc = (px > 239) ? 239 : px;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        row = rl + r - 1;
        if (row < 0) row = 0;
        if (row > 159) row = 159;
        col = cc + c - 1;
        if (col < 0) col = 0;
        if (col > 239) col = 239;
        check($sformatf("%s_r%0d_c%0d", tag, r, c), 32'(win(r, c)), 32'(ref_pix[row][col]));
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    nf_count = 0;
    rstN = 1'b1;
    bus.pxlInRed = '0; bus.pxlInGreen = '0; bus.pxlInBlue = '0;
    bus.pxlInValid = 1'b0; bus.lineStartIn = 1'b0; bus.frameStartIn = 1'b0;
    bus.nextLine = 1'b0; bus.cacheUpdate = 1'b0; bus.curPxl = '0;
    #2 rstN = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("rst_win_r%0d_c%0d", r, c), 32'(win(r, c)), 32'd0);
    check("rst_same_line", 32'(bus.sameLine), 32'd1);
    check("rst_new_frame", 32'(bus.newFrame), 32'd0);
    check("rst_overrun", 32'(bus.overrunErr), 32'd0);
    rstN = 1'b1;
    tick();

    // Frame fill
    write_line(0, 0, 1'b1, 1'b0);
    tick();
    check("fill_l0_same_line", 32'(bus.sameLine), 32'd1);
    check("fill_l0_no_new_frame", 32'(nf_count), 32'd0);
    write_line(1, 3, 1'b1, 1'b0);
    repeat (4) tick();
    check("fill_new_frame_once", 32'(nf_count), 32'd1);
    check("fill_l1_same_line", 32'(bus.sameLine), 32'd0);

    // Advance timing
    pulse_next();
    repeat (3) tick();
    check("adv_next_only", 32'(bus.sameLine), 32'd0);
    pulse_update();
    repeat (2) tick();
    check("adv_after_update", 32'(bus.sameLine), 32'd1);
    write_line(2, 0, 1'b0, 1'b1);
    repeat (2) tick();
    check("l2_done_same_line", 32'(bus.sameLine), 32'd0);

    // Window at rdLine 1, latency and column edges
    chk_win(1, 20, "win_l1_p20");
    bus.curPxl = 8'd10;
    tick();
    check("lat_one_edge_old", 32'(win(1, 1)), 32'(ref_pix[1][20]));
    tick();
    check("lat_two_edges_new", 32'(win(1, 1)), 32'(ref_pix[1][10]));
    chk_win(1, 10, "win_l1_p10");
    chk_win(1, 0, "win_l1_p0");
    chk_win(1, 239, "win_l1_p239");
    chk_win(1, 250, "win_l1_p250");
    for (int i = 0; i < 3; i++)
      chk_win(1, int'($urandom_range(0, 239)), $sformatf("win_l1_rnd%0d", i));

    // Simultaneous nextLine + cacheUpdate
    pulse_both();
    repeat (2) tick();
    check("adv_simultaneous", 32'(bus.sameLine), 32'd1);
    write_line(3, 0, 1'b0, 1'b0);
    repeat (2) tick();
    check("l3_no_overrun", 32'(bus.overrunErr), 32'd0);
    chk_win(2, int'($urandom_range(0, 239)), "win_l2_rnd");

    // Overrun with reader stalled at line 2
    write_line(4, 0, 1'b0, 1'b0);
    repeat (2) tick();
    check("l4_overrun", 32'(bus.overrunErr), 32'd1);
    bus.frameStartIn = 1'b1; tick(); bus.frameStartIn = 1'b0;
    repeat (2) tick();
    check("fs_clears_overrun", 32'(bus.overrunErr), 32'd0);
    check("fs_same_line", 32'(bus.sameLine), 32'd1);
    pulse_update();
    tick();

    // Second frame: top-row clamp, then full frame and bottom-row clamp
    write_line(0, 0, 1'b0, 1'b0);
    write_line(1, 0, 1'b0, 1'b0);
    repeat (4) tick();
    check("f2_new_frame", 32'(nf_count), 32'd2);
    check("f2_same_line", 32'(bus.sameLine), 32'd0);
    chk_win(0, 0, "win_f2_l0_p0");
    chk_win(0, int'($urandom_range(0, 239)), "win_f2_l0_rnd");
    for (int ln = 2; ln < 160; ln++)
      write_line(ln, (ln % 16 == 0) ? 2 : 0, 1'b0, 1'b0);
    repeat (2) tick();
    check("full_frame_same_line", 32'(bus.sameLine), 32'd0);
    check("full_frame_new_frame", 32'(nf_count), 32'd2);
    for (int i = 0; i < 159; i++) begin
      pulse_both();
      tick();
    end
    repeat (2) tick();
    check("l159_no_overrun", 32'(bus.overrunErr), 32'd0);
    chk_win(159, 239, "win_l159_p239");
    chk_win(159, int'($urandom_range(0, 239)), "win_l159_rnd");
    write_line(-1, 0, 1'b0, 1'b0);
    write_line(-1, 0, 1'b0, 1'b0);
    repeat (2) tick();
    check("post_frame_overrun", 32'(bus.overrunErr), 32'd1);

    // Asynchronous reset mid-line
    bus.lineStartIn = 1'b1; tick(); bus.lineStartIn = 1'b0;
    for (int p = 0; p < 100; p++) put_pxl(24'($urandom));
    #2 rstN = 1'b0;
    #1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("async_rst_win_r%0d_c%0d", r, c), 32'(win(r, c)), 32'd0);
    check("async_rst_same_line", 32'(bus.sameLine), 32'd1);
    check("async_rst_overrun", 32'(bus.overrunErr), 32'd0);
    check("async_rst_new_frame", 32'(bus.newFrame), 32'd0);
    repeat (2) tick();
    rstN = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
